// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the RV32I multi-cycle control sequencer: datapath
// widths, the sequencer state enum, the opcode values it recognises, the
// write-back source encoding and the reset value of the instruction register.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN           = 32;
    localparam int REG_SELECT_LEN = 5;

    // ADDI x0,x0,0 -- the instruction register holds a harmless word after reset
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // funct3 of the shift-right group, the only OP-IMM group where IR[30] matters
    localparam logic [2:0] FUNCT3_SR  = 3'b101;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_OP,
        CLS_OP_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_LUI
    } op_class_t;

    typedef struct packed {
        op_class_t                 cls;
        logic [REG_SELECT_LEN-1:0] rs1;
        logic [REG_SELECT_LEN-1:0] rs2;
        logic [REG_SELECT_LEN-1:0] rd;
        logic [2:0]                funct3;
        logic                      alu_signal;
        logic                      legal;
    } decode_t;

    // Instruction classes that produce a register result (before the rd = 0 filter)
    function automatic logic class_writes_rd(input op_class_t cls);
        return (cls == CLS_OP) || (cls == CLS_OP_IMM) || (cls == CLS_LOAD) ||
               (cls == CLS_JAL) || (cls == CLS_LUI);
    endfunction

    function automatic logic [1:0] class_wb_sel(input op_class_t cls);
        logic [1:0] sel;
        case (cls)
            CLS_LOAD: sel = WB_MEM;
            CLS_JAL:  sel = WB_PC4;
            CLS_LUI:  sel = WB_IMM;
            default:  sel = WB_ALU;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
// Purely combinational field extraction for the control sequencer.
// Ports:
//   i_ir   in   XLEN      instruction word to decode
//   o_dec  out  decode_t  opcode class, rs1/rs2/rd, funct3, alu_signal, legal
// -----------------------------------------------------------------------------
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] i_ir,
    output decode_t         o_dec
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_unused_bits;

    assign w_opcode = i_ir[6:0];
    assign w_funct3 = i_ir[14:12];

    // Immediate / funct7 bits other than IR[30] are consumed by the datapath,
    // not by the sequencer.
    assign w_unused_bits = ^{i_ir[31], i_ir[29:25]};

    always_comb begin
        o_dec            = '0;
        o_dec.cls        = CLS_ILLEGAL;
        o_dec.rs1        = i_ir[19:15];
        o_dec.rs2        = i_ir[24:20];
        o_dec.rd         = i_ir[11:7];
        o_dec.funct3     = w_funct3;
        o_dec.alu_signal = 1'b0;
        o_dec.legal      = 1'b1;

        case (w_opcode)
            OPC_OP: begin
                o_dec.cls        = CLS_OP;
                o_dec.alu_signal = i_ir[30];
            end
            OPC_OP_IMM: begin
                o_dec.cls = CLS_OP_IMM;
                // For immediates IR[30] is only an SRA selector in the shift-right
                // group; elsewhere it is an immediate bit.
                o_dec.alu_signal = (w_funct3 == FUNCT3_SR) ? i_ir[30] : 1'b0;
            end
            OPC_LOAD:   o_dec.cls = CLS_LOAD;
            OPC_STORE:  o_dec.cls = CLS_STORE;
            OPC_BRANCH: o_dec.cls = CLS_BRANCH;
            OPC_JAL:    o_dec.cls = CLS_JAL;
            OPC_LUI:    o_dec.cls = CLS_LUI;
            default:    o_dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Multi-cycle Moore control FSM for the RV32I core. Fetches one instruction
// over a req/ack handshake into the instruction register, then sequences
// decode, execute, memory and write-back. Every output is a register whose
// next value is derived from the next state, so outputs line up with the
// state they belong to.
// Ports:
//   clk, reset                       clock / asynchronous active-high reset
//   imem_req/imem_ack/imem_rdata     instruction fetch handshake
//   instruction                      instruction register
//   dmem_req/dmem_we/dmem_ack        data-memory handshake
//   reg_array_*                      rd/rs1/rs2 selects and write strobe (act-low)
//   wb_sel                           write-back source select
//   alu_*                            ALU enable (act-low), funct3, SUB/SRA, B-mux
//   branch_enable_n/branch_taken     branch compare enable and result
//   pc_load/pc_src                   PC update strobe and source
//   trap                             sticky illegal-instruction flag
// -----------------------------------------------------------------------------
module control_sequencer
    import cpu_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    output logic                      imem_req,
    input  logic                      imem_ack,
    input  logic [XLEN-1:0]           imem_rdata,
    output logic [XLEN-1:0]           instruction,
    output logic                      dmem_req,
    output logic                      dmem_we,
    input  logic                      dmem_ack,
    output logic                      reg_array_enable_n,
    output logic [REG_SELECT_LEN-1:0] reg_array_store,
    output logic [REG_SELECT_LEN-1:0] reg_array_enable_a,
    output logic [REG_SELECT_LEN-1:0] reg_array_enable_b,
    output logic [1:0]                wb_sel,
    output logic                      alu_enable_n,
    output logic [2:0]                alu_opcode,
    output logic                      alu_signal,
    output logic                      alu_b_sel,
    output logic                      branch_enable_n,
    input  logic                      branch_taken,
    output logic                      pc_load,
    output logic                      pc_src,
    output logic                      trap
);

    state_t                    r_state;
    logic [XLEN-1:0]           r_ir;
    logic                      r_imem_req;
    logic                      r_dmem_req;
    logic                      r_dmem_we;
    logic                      r_reg_enable_n;
    logic [REG_SELECT_LEN-1:0] r_rd;
    logic [REG_SELECT_LEN-1:0] r_rs1;
    logic [REG_SELECT_LEN-1:0] r_rs2;
    logic [1:0]                r_wb_sel;
    logic                      r_alu_enable_n;
    logic [2:0]                r_alu_opcode;
    logic                      r_alu_signal;
    logic                      r_alu_b_sel;
    logic                      r_branch_enable_n;
    logic                      r_pc_load;
    logic                      r_pc_src;
    logic                      r_trap;

    state_t                    w_state_next;
    logic                      w_fetch_accept;
    logic [XLEN-1:0]           w_ir_next;
    logic                      w_imem_req_next;
    logic                      w_dmem_req_next;
    logic                      w_dmem_we_next;
    logic                      w_reg_enable_n_next;
    logic [REG_SELECT_LEN-1:0] w_rd_next;
    logic [REG_SELECT_LEN-1:0] w_rs1_next;
    logic [REG_SELECT_LEN-1:0] w_rs2_next;
    logic [1:0]                w_wb_sel_next;
    logic                      w_alu_enable_n_next;
    logic [2:0]                w_alu_opcode_next;
    logic                      w_alu_signal_next;
    logic                      w_alu_b_sel_next;
    logic                      w_branch_enable_n_next;
    logic                      w_pc_load_next;
    logic                      w_pc_src_next;
    logic                      w_trap_next;
    logic                      w_is_mem;
    decode_t                   w_dec;

    // The decoder looks at the word about to sit in IR, so the register selects
    // are already valid in the DECODE cycle rather than one cycle later.
    assign w_fetch_accept = (r_state == S_FETCH) && imem_ack;
    assign w_ir_next      = w_fetch_accept ? imem_rdata : r_ir;

    instr_decoder u_instr_decoder (
        .i_ir  (w_ir_next),
        .o_dec (w_dec)
    );

    assign w_is_mem = (w_dec.cls == CLS_LOAD) || (w_dec.cls == CLS_STORE);

    always_comb begin
        // Selects and qualifiers hold; strobes fall back to inactive.
        w_state_next           = r_state;
        w_rd_next              = r_rd;
        w_rs1_next             = r_rs1;
        w_rs2_next             = r_rs2;
        w_wb_sel_next          = r_wb_sel;
        w_alu_opcode_next      = r_alu_opcode;
        w_alu_signal_next      = r_alu_signal;
        w_alu_b_sel_next       = r_alu_b_sel;
        w_pc_src_next          = r_pc_src;
        w_trap_next            = r_trap;
        w_imem_req_next        = 1'b0;
        w_dmem_req_next        = 1'b0;
        w_dmem_we_next         = 1'b0;
        w_reg_enable_n_next    = 1'b1;
        w_alu_enable_n_next    = 1'b1;
        w_branch_enable_n_next = 1'b1;
        w_pc_load_next         = 1'b0;

        // Transition part
        case (r_state)
            S_START: w_state_next = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    w_state_next = S_DECODE;
                    w_rd_next    = w_dec.rd;
                    w_rs1_next   = w_dec.rs1;
                    w_rs2_next   = w_dec.rs2;
                end
            end
            S_DECODE: w_state_next = w_dec.legal ? S_EXECUTE : S_TRAP;
            S_EXECUTE: begin
                // branch_taken is only meaningful while branch_enable_n is low,
                // i.e. on the edge that leaves EXECUTE of a branch.
                if (w_dec.cls == CLS_BRANCH) begin
                    w_pc_src_next = branch_taken;
                end else if (w_dec.cls == CLS_JAL) begin
                    w_pc_src_next = 1'b1;
                end
                w_state_next = w_is_mem ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY:    if (dmem_ack) w_state_next = S_WRITEBACK;
            S_WRITEBACK: w_state_next = S_FETCH;
            S_TRAP:      w_state_next = S_TRAP;
            default:     w_state_next = S_START;
        endcase

        // Output part: registered Moore outputs of the state being entered
        case (w_state_next)
            S_FETCH: begin
                w_imem_req_next = 1'b1;
                w_pc_src_next   = 1'b0;
            end
            S_EXECUTE: begin
                w_alu_enable_n_next    = 1'b0;
                w_alu_opcode_next      = w_is_mem ? 3'b000 : w_dec.funct3;
                w_alu_signal_next      = w_is_mem ? 1'b0 : w_dec.alu_signal;
                w_alu_b_sel_next       = (w_dec.cls == CLS_OP_IMM) || w_is_mem;
                w_branch_enable_n_next = (w_dec.cls != CLS_BRANCH);
            end
            S_MEMORY: begin
                w_dmem_req_next = 1'b1;
                w_dmem_we_next  = (w_dec.cls == CLS_STORE);
            end
            S_WRITEBACK: begin
                w_pc_load_next = 1'b1;
                if (class_writes_rd(w_dec.cls) && (w_dec.rd != '0)) begin
                    w_reg_enable_n_next = 1'b0;
                    w_wb_sel_next       = class_wb_sel(w_dec.cls);
                end
            end
            S_TRAP:  w_trap_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_START;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir              <= NOP_INSTR;
            r_imem_req        <= 1'b0;
            r_dmem_req        <= 1'b0;
            r_dmem_we         <= 1'b0;
            r_reg_enable_n    <= 1'b1;
            r_rd              <= '0;
            r_rs1             <= '0;
            r_rs2             <= '0;
            r_wb_sel          <= WB_ALU;
            r_alu_enable_n    <= 1'b1;
            r_alu_opcode      <= 3'b000;
            r_alu_signal      <= 1'b0;
            r_alu_b_sel       <= 1'b0;
            r_branch_enable_n <= 1'b1;
            r_pc_load         <= 1'b0;
            r_pc_src          <= 1'b0;
            r_trap            <= 1'b0;
        end else begin
            r_ir              <= w_ir_next;
            r_imem_req        <= w_imem_req_next;
            r_dmem_req        <= w_dmem_req_next;
            r_dmem_we         <= w_dmem_we_next;
            r_reg_enable_n    <= w_reg_enable_n_next;
            r_rd              <= w_rd_next;
            r_rs1             <= w_rs1_next;
            r_rs2             <= w_rs2_next;
            r_wb_sel          <= w_wb_sel_next;
            r_alu_enable_n    <= w_alu_enable_n_next;
            r_alu_opcode      <= w_alu_opcode_next;
            r_alu_signal      <= w_alu_signal_next;
            r_alu_b_sel       <= w_alu_b_sel_next;
            r_branch_enable_n <= w_branch_enable_n_next;
            r_pc_load         <= w_pc_load_next;
            r_pc_src          <= w_pc_src_next;
            r_trap            <= w_trap_next;
        end
    end

    assign imem_req           = r_imem_req;
    assign instruction        = r_ir;
    assign dmem_req           = r_dmem_req;
    assign dmem_we            = r_dmem_we;
    assign reg_array_enable_n = r_reg_enable_n;
    assign reg_array_store    = r_rd;
    assign reg_array_enable_a = r_rs1;
    assign reg_array_enable_b = r_rs2;
    assign wb_sel             = r_wb_sel;
    assign alu_enable_n       = r_alu_enable_n;
    assign alu_opcode         = r_alu_opcode;
    assign alu_signal         = r_alu_signal;
    assign alu_b_sel          = r_alu_b_sel;
    assign branch_enable_n    = r_branch_enable_n;
    assign pc_load            = r_pc_load;
    assign pc_src             = r_pc_src;
    assign trap               = r_trap;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control FSM for the RV32I core. It fetches one instruction at a time over a req/ack instruction-memory handshake and holds it in an instruction register. It then steps the ALU, branch unit, register array, data-memory port and program counter through decode, execute, memory and writeback. It is the only driver of the enable and select lines of those units.

## Interface
- XLEN, 32, datapath width
- REG_SELECT_LEN, 5, register-select width
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  XLEN  fetched instruction
- instruction  out  XLEN  instruction register (IR)
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_ack  in  1  data-memory access complete
- reg_array_enable_n  out  1  register write strobe, active-low
- reg_array_store  out  REG_SELECT_LEN  rd
- reg_array_enable_a / reg_array_enable_b  out  REG_SELECT_LEN  rs1 / rs2
- wb_sel  out  2  0 = ALU, 1 = memory, 2 = PC+4, 3 = immediate
- alu_enable_n  out  1  ALU enable, active-low
- alu_opcode  out  3  funct3
- alu_signal  out  1  SUB/SRA select
- alu_b_sel  out  1  0 = rs2, 1 = immediate
- branch_enable_n  out  1  branch compare enable, active-low
- branch_taken  in  1  compare result, valid while branch_enable_n = 0
- pc_load  out  1  one-cycle PC update strobe
- pc_src  out  1  0 = PC+4, 1 = branch/jump target
- trap  out  1  sticky illegal-instruction flag

## Operation
- States: START, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
- START → FETCH unconditionally.
- FETCH: imem_req = 1 until imem_ack. On the ack cycle, IR ← imem_rdata and the FSM moves to DECODE.
- DECODE: drives rs1/rs2/rd from IR[19:15], IR[24:20] and IR[11:7].
  - Supported opcodes: OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, LUI 0110111.
  - Any other opcode → TRAP.
- EXECUTE, ALU fields: alu_enable_n = 0; alu_opcode = funct3.
  - alu_signal = IR[30] for OP, and for OP-IMM only when funct3 = 101; otherwise 0.
  - LOAD/STORE force alu_opcode = 000 and alu_signal = 0, with alu_b_sel = 1 (address add).
- EXECUTE, BRANCH: also drives branch_enable_n = 0 and samples branch_taken into a pc_src register.
- EXECUTE, JAL: sets pc_src = 1.
- EXECUTE next state: LOAD/STORE → MEMORY; all others → WRITEBACK.
- MEMORY: dmem_req = 1 and dmem_we = (STORE), held until dmem_ack, then → WRITEBACK.
- WRITEBACK: pc_load = 1 for one cycle, then → FETCH.
  - reg_array_enable_n = 0 for OP, OP-IMM, LOAD, JAL and LUI when rd ≠ 0.
  - Writes are suppressed for rd = 0, STORE and BRANCH.
  - wb_sel: OP/OP-IMM = 0, LOAD = 1, JAL = 2, LUI = 3.
- TRAP: absorbing state, trap = 1, all strobes inactive; only reset exits.
- pc_src is cleared in FETCH.

## Timing
- All outputs are registered; the FSM is Moore.
- Reset values:
  - state = START
  - imem_req, dmem_req, dmem_we, pc_load, pc_src, trap = 0
  - all active-low enables = 1
  - IR = 0x00000013 (NOP)
  - selects, alu_opcode, alu_signal, alu_b_sel, wb_sel = 0
- Reset asserted mid-instruction aborts immediately: no pc_load, and req lines drop asynchronously.
- Latency with zero-wait acks:
  - ALU/branch/JAL/LUI: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - LOAD/STORE: 5 cycles.
- Handshakes:
  - A req stays high with stable qualifiers until its ack, and falls the cycle after the ack.
  - An ack without a pending req is ignored.
- imem_ack in the same cycle FETCH is entered is accepted.
- branch_taken is only sampled in EXECUTE of a BRANCH.

## Structure
- Package cpu_pkg holds:
  - the state enum
  - opcode localparams
  - the wb_sel encoding
  - the NOP constant
  - XLEN / REG_SELECT_LEN
- Sub-module instr_decoder, purely combinational: IR → opcode class, rs1/rs2/rd, funct3, alu_signal, legal.

## Test plan
- Reset, then release with imem_ack tied high and ADDI x1,x0,5 (0x00500093): pc_load on cycle 4 and reg_array_enable_n low in WRITEBACK with store = 1, wb_sel = 0, alu_b_sel = 1.
- SUB x3,x1,x2 (0x402081B3): alu_signal = 1, alu_opcode = 000, enable_a = 1, enable_b = 2.
- LW x5,0(x1) with dmem_ack delayed 3 cycles: dmem_req held 4 cycles with dmem_we = 0, then wb_sel = 1 and the write strobe fires; total 8 cycles.
- BEQ with branch_taken = 1, then a second BEQ with branch_taken = 0: pc_src = 1 then 0 at the respective pc_load, and no register write.
- ADDI x0,x0,1 followed by an opcode 0x7F word: no write strobe for rd = 0, then trap = 1 and no further imem_req until reset.
- Assert reset during MEMORY of a store: dmem_req drops immediately, state = START, and the next fetch begins 2 cycles after release.
